chip8_fetch: RTL and testbench

Instruction fetch stage for the CHIP-8 core. Sits directly downstream of the 4096x8 synchronous program ROM: drives its address, absorbs its one-cycle read latency and assembles two consecutive bytes into a big-endian 16-bit opcode. The opcode goes to the decode/execute stage over a valid/ready handshake. The stage also owns the program counter and accepts absolute PC loads for jumps, calls, returns and skips.

---
 rtl/chip8_fetch_if.sv | 22 ++
 rtl/chip8_fetch.sv | 77 +++++++
 tb/tb_chip8_fetch.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/chip8_fetch_if.sv
// Signal bundle between the CHIP-8 fetch stage, its program ROM, the PC-load
// source and the decode/execute consumer of assembled opcodes.
interface chip8_fetch_if;
  logic [11:0] rom_addr;
  logic [7:0]  rom_dout;
  logic        pc_load;
  logic [11:0] pc_in;
  logic [15:0] opcode;
  logic        opcode_valid;
  logic        opcode_ready;
  logic [11:0] instr_addr;

  modport master (
    output rom_addr, opcode, opcode_valid, instr_addr,
    input  rom_dout, pc_load, pc_in, opcode_ready
  );

  modport slave (
    input  rom_addr, opcode, opcode_valid, instr_addr,
    output rom_dout, pc_load, pc_in, opcode_ready
  );
endinterface

// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch: reads two bytes from a 1-cycle-latency ROM,
// assembles a big-endian opcode and offers it to the consumer; owns the PC.
module chip8_fetch #(
  parameter logic [11:0] RESET_PC = 12'h200
) (
  input  logic              clk,
  input  logic              reset,
  chip8_fetch_if.master     bus,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    FETCH_HI   = 2'd0,
    FETCH_LO   = 2'd1,
    CAPTURE_LO = 2'd2,
    HOLD       = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [11:0] pc;
  logic [11:0] pc_next;
  logic [15:0] opcode_q;
  logic [11:0] pc_plus1;
  logic [11:0] pc_plus2;

  assign pc_plus1 = pc + 12'd1;
  assign pc_plus2 = pc + 12'd2;

  // Handshake: a transfer happens on a rising edge where opcode_valid and
  // opcode_ready are both high; while valid && !ready, opcode and instr_addr
  // are held. opcode_valid is a pure decode of HOLD, and ready is ignored
  // in every other state.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      FETCH_HI:   state_next = FETCH_LO;
      FETCH_LO:   state_next = CAPTURE_LO;
      CAPTURE_LO: state_next = HOLD;
      HOLD: begin
        if (bus.opcode_ready) begin
          state_next = FETCH_HI;
          pc_next    = pc_plus2;
        end
      end
      default:    state_next = FETCH_HI;
    endcase
    // A PC load overrides everything, including a same-cycle accept.
    if (bus.pc_load) begin
      state_next = FETCH_HI;
      pc_next    = bus.pc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH_HI;
      pc       <= RESET_PC;
      opcode_q <= 16'h0000;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (!bus.pc_load && state == FETCH_LO)
        opcode_q[15:8] <= bus.rom_dout;
      if (!bus.pc_load && state == CAPTURE_LO)
        opcode_q[7:0] <= bus.rom_dout;
    end
  end

  assign bus.rom_addr     = (state == FETCH_HI) ? pc : pc_plus1;
  assign bus.opcode       = opcode_q;
  assign bus.opcode_valid = (state == HOLD);
  assign bus.instr_addr   = pc;
  assign fsm_state        = state;

endmodule

// File: tb/tb_chip8_fetch.sv
// Directed bench for chip8_fetch: a ROM model, a stimulus sequence with
// cycle-exact checks, and a monitor that scores every accepted opcode.
module tb_chip8_fetch;
  logic       clk;
  logic       reset;
  logic [1:0] fsm_state;

  chip8_fetch_if bus ();

  chip8_fetch #(.RESET_PC(12'h200)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous ROM, one cycle of read latency
  logic [7:0] mem [0:4095];
  always @(posedge clk) bus.rom_dout <= mem[bus.rom_addr];

  // scoreboard: {instr_addr, opcode}
  logic [27:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_op(input logic [11:0] addr, input logic [15:0] op);
    exp_q.push_back({addr, op});
  endtask

  // monitor: every transfer must match the head of the expected queue
  always @(negedge clk) begin
    logic [27:0] e;
    if (!reset && bus.opcode_valid && bus.opcode_ready) begin
      if (exp_q.size() == 0) begin
        check("xfer_unexpected", {4'h0, bus.instr_addr, bus.opcode}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("xfer_addr", {20'h0, bus.instr_addr}, {20'h0, e[27:16]});
        check("xfer_opcode", {16'h0, bus.opcode}, {16'h0, e[15:0]});
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'hA5 ^ i[7:0];
    mem[12'h200] = 8'h00; mem[12'h201] = 8'hE0;
    mem[12'h202] = 8'h12; mem[12'h203] = 8'h34;
    mem[12'h204] = 8'hA2; mem[12'h205] = 8'hF0;
    mem[12'h206] = 8'h11; mem[12'h207] = 8'h22;
    mem[12'h3A4] = 8'h6A; mem[12'h3A5] = 8'h05;
    mem[12'hFFF] = 8'hD1; mem[12'h000] = 8'h23;
    mem[12'h300] = 8'hC3; mem[12'h301] = 8'h3C;
    mem[12'h250] = 8'h7B; mem[12'h251] = 8'h01;

    reset = 1'b1;
    bus.pc_load = 1'b0;
    bus.pc_in = 12'h000;
    bus.opcode_ready = 1'b1;
    step();
    step();
    check("rst_valid", {31'h0, bus.opcode_valid}, 32'h0);
    check("rst_rom_addr", {20'h0, bus.rom_addr}, 32'h200);
    check("rst_instr_addr", {20'h0, bus.instr_addr}, 32'h200);
    check("rst_opcode", {16'h0, bus.opcode}, 32'h0);

    // reset fetch, ready tied high
    expect_op(12'h200, 16'h00E0);
    expect_op(12'h202, 16'h1234);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("boot_valid", {31'h0, bus.opcode_valid}, (c == 3 || c == 7) ? 32'h1 : 32'h0);
      if (c == 0) check("boot_rom_addr0", {20'h0, bus.rom_addr}, 32'h200);
      if (c == 1) check("boot_rom_addr1", {20'h0, bus.rom_addr}, 32'h201);
      if (c == 7) check("boot_addr2", {20'h0, bus.instr_addr}, 32'h202);
      step();
    end

    // backpressure
    bus.opcode_ready = 1'b0;
    expect_op(12'h204, 16'hA2F0);
    step(); step(); step();
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", {31'h0, bus.opcode_valid}, 32'h1);
      check("bp_opcode", {16'h0, bus.opcode}, 32'hA2F0);
      check("bp_instr_addr", {20'h0, bus.instr_addr}, 32'h204);
      step();
    end
    bus.opcode_ready = 1'b1;
    step();
    bus.opcode_ready = 1'b0;
    check("bp_advance", {20'h0, bus.instr_addr}, 32'h206);
    check("bp_after_valid", {31'h0, bus.opcode_valid}, 32'h0);

    // jump during CAPTURE_LO aborts the 0x206 fetch
    step(); step();
    check("jmp_state", {30'h0, fsm_state}, 32'h2);
    bus.pc_load = 1'b1;
    bus.pc_in = 12'h3A4;
    bus.opcode_ready = 1'b1;
    expect_op(12'h3A4, 16'h6A05);
    step();
    bus.pc_load = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("jmp_valid", {31'h0, bus.opcode_valid}, (c == 3) ? 32'h1 : 32'h0);
      if (c == 0) check("jmp_rom_addr", {20'h0, bus.rom_addr}, 32'h3A4);
      if (c < 3) step();
    end
    check("jmp_instr_addr", {20'h0, bus.instr_addr}, 32'h3A4);
    step();

    // wrap-around at the top of memory
    bus.pc_load = 1'b1;
    bus.pc_in = 12'hFFF;
    expect_op(12'hFFF, 16'hD123);
    step();
    bus.pc_load = 1'b0;
    check("wrap_rom_addr0", {20'h0, bus.rom_addr}, 32'hFFF);
    step();
    check("wrap_rom_addr1", {20'h0, bus.rom_addr}, 32'h000);
    step(); step();
    check("wrap_valid", {31'h0, bus.opcode_valid}, 32'h1);
    check("wrap_instr_addr", {20'h0, bus.instr_addr}, 32'hFFF);
    step();
    check("wrap_after", {20'h0, bus.instr_addr}, 32'h001);

    // pc_load and opcode_ready together in HOLD
    bus.pc_load = 1'b1;
    bus.pc_in = 12'h300;
    expect_op(12'h300, 16'hC33C);
    step();
    bus.pc_load = 1'b0;
    step(); step(); step();
    check("sim_valid", {31'h0, bus.opcode_valid}, 32'h1);
    check("sim_instr_addr", {20'h0, bus.instr_addr}, 32'h300);
    bus.pc_load = 1'b1;
    bus.pc_in = 12'h250;
    expect_op(12'h250, 16'h7B01);
    step();
    bus.pc_load = 1'b0;
    check("sim_load_wins", {20'h0, bus.instr_addr}, 32'h250);
    check("sim_state", {30'h0, fsm_state}, 32'h0);
    step(); step(); step();
    check("sim_valid2", {31'h0, bus.opcode_valid}, 32'h1);
    step();

    // reset during FETCH_LO at pc=0x456
    bus.pc_load = 1'b1;
    bus.pc_in = 12'h456;
    step();
    bus.pc_load = 1'b0;
    step();
    check("mrst_state_before", {30'h0, fsm_state}, 32'h1);
    check("mrst_pc_before", {20'h0, bus.instr_addr}, 32'h456);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_valid", {31'h0, bus.opcode_valid}, 32'h0);
    check("mrst_rom_addr", {20'h0, bus.rom_addr}, 32'h200);
    check("mrst_state", {30'h0, fsm_state}, 32'h0);
    expect_op(12'h200, 16'h00E0);
    for (int c = 0; c < 4; c++) begin
      check("mrst_fetch_valid", {31'h0, bus.opcode_valid}, (c == 3) ? 32'h1 : 32'h0);
      step();
    end
    bus.opcode_ready = 1'b0;
    step(); step();
    check("queue_drained", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
